// File: rtl/mem_bus_pkg.sv
// Shared encodings for the fetch / load-store memory arbiter.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_e;

  localparam logic       GNT_IF   = 1'b0;
  localparam logic       GNT_D    = 1'b1;
  localparam logic [3:0] BE_WORD  = 4'hF;
  localparam int         STREAK_W = 4;

  function automatic logic [STREAK_W-1:0] streak_inc(input logic [STREAK_W-1:0] cur,
                                                     input logic [STREAK_W-1:0] lim);
    logic [STREAK_W-1:0] nxt;
    if (cur >= lim) begin
      nxt = lim;
    end else begin
      nxt = cur + 4'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mem_arb_grant_sel.sv
// Grant decision between fetch and data, with the fetch starvation streak counter.
module mem_arb_grant_sel
  import mem_bus_pkg::*;
#(
  parameter int STREAK_MAX = 4
) (
  input  logic clk,
  input  logic cpu_resetn,
  input  logic if_req,
  input  logic d_req,
  input  logic idle,
  output logic grant,
  output logic grant_valid
);

  localparam logic [STREAK_W-1:0] STREAK_LIM = STREAK_W'(STREAK_MAX);

  logic [STREAK_W-1:0] streak_r;
  logic                force_if_s;

  // data normally wins; fetch wins once data has taken STREAK_MAX grants in a row
  always_comb begin
    force_if_s  = (streak_r == STREAK_LIM);
    grant_valid = idle & (if_req | d_req);
    if (d_req && !(if_req && force_if_s)) begin
      grant = GNT_D;
    end else begin
      grant = GNT_IF;
    end
  end

  // streak only moves in IDLE, where the grant is actually taken
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      streak_r <= '0;
    end else if (idle) begin
      if (!if_req || (grant == GNT_IF)) begin
        streak_r <= '0;
      end else begin
        streak_r <= streak_inc(streak_r, STREAK_LIM);
      end
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Fixed-latency arbiter sharing one single-port memory between fetch and load/store.
// Optional stall counters are built when MEM_BUS_ARB_PERF_CNT_EN is defined.
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STREAK_MAX = 4
) (
  input  logic              clk,
  input  logic              cpu_resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [3:0]        d_be,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
`ifdef MEM_BUS_ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_stall,
  output logic [31:0]       perf_d_stall
`endif
);

  localparam logic [ADDR_W-1:0] ALIGN_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};
  localparam logic [2:0]        LAT_LOAD   = 3'(MEM_LAT);

  arb_state_e state_r;
  logic       gnt_r;
  logic [2:0] cnt_r;
  logic       idle_s;
  logic       grant_s;
  logic       grant_valid_s;

  assign idle_s = (state_r == IDLE);

  mem_arb_grant_sel #(
    .STREAK_MAX (STREAK_MAX)
  ) u_grant_sel (
    .clk         (clk),
    .cpu_resetn  (cpu_resetn),
    .if_req      (if_req),
    .d_req       (d_req),
    .idle        (idle_s),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  // access FSM; every memory-side and response output is a register of this block
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      state_r   <= IDLE;
      gnt_r     <= GNT_IF;
      cnt_r     <= 3'd0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= 32'h0;
      d_rdata   <= 32'h0;
    end else begin
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            gnt_r   <= grant_s;
            mem_en  <= 1'b1;
            state_r <= ISSUE;
            if (grant_s == GNT_D) begin
              mem_we    <= d_we;
              mem_be    <= d_be;
              mem_addr  <= d_addr & ALIGN_MASK;
              mem_wdata <= d_wdata;
            end else begin
              mem_we    <= 1'b0;
              mem_be    <= BE_WORD;
              mem_addr  <= if_addr & ALIGN_MASK;
              mem_wdata <= 32'h0;
            end
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          cnt_r   <= LAT_LOAD;
          state_r <= WAIT;
        end
        WAIT: begin
          cnt_r <= cnt_r - 3'd1;
          if (cnt_r == 3'd1) begin
            state_r <= RESP;
            if (gnt_r == GNT_D) begin
              d_rdata <= mem_rdata;
              d_ack   <= 1'b1;
            end else begin
              if_rdata <= mem_rdata;
              if_ack   <= 1'b1;
            end
          end
        end
        RESP: begin
          if_ack  <= 1'b0;
          d_ack   <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef MEM_BUS_ARB_PERF_CNT_EN
  logic if_blk_s;
  logic d_blk_s;

  // a requester is stalled while the other one is taking or holding the bus
  always_comb begin
    if_blk_s = 1'b0;
    d_blk_s  = 1'b0;
    if (state_r == IDLE) begin
      if_blk_s = if_req & grant_valid_s & (grant_s == GNT_D);
      d_blk_s  = d_req & grant_valid_s & (grant_s == GNT_IF);
    end else begin
      if_blk_s = if_req & (gnt_r == GNT_D);
      d_blk_s  = d_req & (gnt_r == GNT_IF);
    end
  end

  // free-running stall counters, wrapping naturally at 2^32
  always_ff @(posedge clk or negedge cpu_resetn) begin
    if (!cpu_resetn) begin
      perf_if_stall <= 32'h0;
      perf_d_stall  <= 32'h0;
    end else begin
      if (if_blk_s) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (d_blk_s) begin
        perf_d_stall <= perf_d_stall + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: acks are scoreboarded against a transaction-level
// memory model; directed corner cases followed by random two-requester traffic.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  localparam int ADDR_W     = 32;
  localparam int MEM_LAT    = 1;
  localparam int STREAK_MAX = 4;

  logic        clk = 1'b0;
  logic        cpu_resetn;
  logic        if_req, if_ack;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_ack;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_BUS_ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall, perf_d_stall;
`endif

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .MEM_LAT(MEM_LAT), .STREAK_MAX(STREAK_MAX)) dut (
    .clk(clk), .cpu_resetn(cpu_resetn),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_BUS_ARB_PERF_CNT_EN
    , .perf_if_stall(perf_if_stall), .perf_d_stall(perf_d_stall)
`endif
  );

  always #5 clk = ~clk;

  int unsigned cyc;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] w;
    if (i == 64) w = 32'h0000_0013;
    else if (i == 256) w = 32'hDEAD_BEEF;
    else w = (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_1234;
    return w;
  endfunction

  // memory macro: synchronous, byte-enabled writes, reads MEM_LAT cycles after mem_en
  logic [31:0] mem [1024];
  logic [31:0] rd_pipe [MEM_LAT];
  bit          init_done;
  assign mem_rdata = rd_pipe[MEM_LAT-1];
  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 1024; i++) mem[i] <= init_word(i);
      init_done <= 1'b1;
    end else if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
    rd_pipe[0] <= mem_en ? mem[mem_addr[11:2]] : 32'h0BAD_F00D;
    for (int i = 1; i < MEM_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rd;
    logic        chk_cyc;
    logic [31:0] ack_cyc;
  } exp_t;

  typedef struct packed {
    logic [31:0] cyc_at;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        chk_wd;
  } mexp_t;

  exp_t        if_q[$];
  exp_t        d_q[$];
  mexp_t       mem_q[$];
  logic        ord_q[$];
  logic [31:0] ref_mem [1024];
  int          tests, fails;
  bit          if_waiting;
  int          if_wait_dacks;

  task automatic chk(input logic ok, input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] req);
    chk(act === req, name, act, req);
  endtask

  task automatic monitor();
    exp_t  e;
    mexp_t m;
    logic  tag;
    logic  prev_en = 1'b0;
    forever begin
      @(negedge clk);
      if (!cpu_resetn) begin
        prev_en = 1'b0;
      end else begin
        if (if_ack) begin
          if (if_q.size() == 0) chk_eq("if_ack_unexpected", 32'd1, 32'd0);
          else begin
            e = if_q.pop_front();
            if (e.chk_rd) chk_eq("if_rdata", if_rdata, e.rdata);
            if (e.chk_cyc) chk_eq("if_ack_cycle", cyc, e.ack_cyc);
          end
          if (ord_q.size() > 0) begin
            tag = ord_q.pop_front();
            chk_eq("grant_order", 32'd0, {31'd0, tag});
          end
          if (if_waiting) begin
            chk(if_wait_dacks <= STREAK_MAX + 1, "if_starved", 32'(if_wait_dacks), 32'(STREAK_MAX + 1));
            if_waiting = 1'b0;
          end
        end
        if (d_ack) begin
          if (d_q.size() == 0) chk_eq("d_ack_unexpected", 32'd1, 32'd0);
          else begin
            e = d_q.pop_front();
            if (e.chk_rd) chk_eq("d_rdata", d_rdata, e.rdata);
            if (e.chk_cyc) chk_eq("d_ack_cycle", cyc, e.ack_cyc);
          end
          if (ord_q.size() > 0) begin
            tag = ord_q.pop_front();
            chk_eq("grant_order", 32'd1, {31'd0, tag});
          end
          if (if_waiting) if_wait_dacks++;
        end
        if (mem_en) begin
          chk_eq("mem_en_pulse", {31'd0, prev_en}, 32'd0);
          chk_eq("mem_addr_align", {30'd0, mem_addr[1:0]}, 32'd0);
          if (mem_q.size() > 0) begin
            m = mem_q.pop_front();
            chk_eq("mem_en_cycle", cyc, m.cyc_at);
            chk_eq("mem_we", {31'd0, mem_we}, {31'd0, m.we});
            chk_eq("mem_be", {28'd0, mem_be}, {28'd0, m.be});
            chk_eq("mem_addr", mem_addr, m.addr);
            if (m.chk_wd) chk_eq("mem_wdata", mem_wdata, m.wdata);
          end
        end
        prev_en = mem_en;
      end
    end
  endtask

  task automatic fetch_txn(input logic [31:0] addr, input bit fixed);
    exp_t  e;
    mexp_t m;
    int    n;
    if_addr = addr;
    if_req  = 1'b1;
    e.rdata = ref_mem[addr[11:2]];
    e.chk_rd = 1'b1;
    e.chk_cyc = fixed;
    e.ack_cyc = cyc + MEM_LAT + 2;
    if_q.push_back(e);
    if (fixed) begin
      m.cyc_at = cyc + 1; m.we = 1'b0; m.be = 4'hF;
      m.addr = addr & 32'hFFFF_FFFC; m.wdata = 32'h0; m.chk_wd = 1'b0;
      mem_q.push_back(m);
    end
    if_waiting = 1'b1;
    if_wait_dacks = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!if_ack && n < 200);
    chk_eq("if_ack_timeout", {31'd0, if_ack}, 32'd1);
    if_req = 1'b0;
  endtask

  task automatic data_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit fixed);
    exp_t  e;
    mexp_t m;
    int    n;
    d_we = we; d_be = be; d_addr = addr; d_wdata = wdata;
    d_req = 1'b1;
    e.rdata = ref_mem[addr[11:2]];
    e.chk_rd = !we;
    e.chk_cyc = fixed;
    e.ack_cyc = cyc + MEM_LAT + 2;
    if (we)
      for (int b = 0; b < 4; b++)
        if (be[b]) ref_mem[addr[11:2]][8*b +: 8] = wdata[8*b +: 8];
    d_q.push_back(e);
    if (fixed) begin
      m.cyc_at = cyc + 1; m.we = we; m.be = be;
      m.addr = addr & 32'hFFFF_FFFC; m.wdata = wdata; m.chk_wd = we;
      mem_q.push_back(m);
    end
    n = 0;
    do begin @(negedge clk); n++; end while (!d_ack && n < 200);
    chk_eq("d_ack_timeout", {31'd0, d_ack}, 32'd1);
    d_req = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
    chk_eq({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    chk_eq({tag, "_mem_be"}, {28'd0, mem_be}, 32'd0);
    chk_eq({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk_eq({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk_eq({tag, "_if_ack"}, {31'd0, if_ack}, 32'd0);
    chk_eq({tag, "_d_ack"}, {31'd0, d_ack}, 32'd0);
    chk_eq({tag, "_if_rdata"}, if_rdata, 32'd0);
    chk_eq({tag, "_d_rdata"}, d_rdata, 32'd0);
  endtask

  initial begin
    int          n, k;
    logic [31:0] r;
`ifdef MEM_BUS_ARB_PERF_CNT_EN
    logic [31:0] pif0, pd0;
`endif
    cpu_resetn = 1'b0;
    if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h0; d_wdata = 32'h0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = init_word(i);
    fork monitor(); join_none

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    cpu_resetn = 1'b1;
    repeat (2) @(negedge clk);

    fetch_txn(32'h0000_0100, 1'b1);
    repeat (2) @(negedge clk);
    data_txn(1'b1, 4'b1000, 32'h0000_0203, 32'hAB00_0000, 1'b1);
    repeat (2) @(negedge clk);
    data_txn(1'b0, 4'hF, 32'h0000_0400, 32'h0, 1'b1);
    repeat (2) @(negedge clk);
    data_txn(1'b1, 4'h0, 32'h0000_0408, 32'h1234_5678, 1'b1);
    repeat (2) @(negedge clk);
    data_txn(1'b0, 4'hF, 32'h0000_0408, 32'h0, 1'b1);
    repeat (2) @(negedge clk);

    // both requesters held: expect D,D,D,D,IF twice
    for (int g = 0; g < 10; g++) ord_q.push_back((g % 5) != 4);
    for (int g = 0; g < 2; g++) if_q.push_back('{ref_mem[4], 1'b1, 1'b0, 32'd0});
    for (int g = 0; g < 8; g++) d_q.push_back('{ref_mem[288], 1'b1, 1'b0, 32'd0});
    if_addr = 32'h0000_0010; if_req = 1'b1;
    d_addr = 32'h0000_0480; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    if_waiting = 1'b1; if_wait_dacks = 0;
    n = 0; k = 0;
    while (k < 10 && n < 400) begin
      @(negedge clk); n++;
      if (if_ack || d_ack) k++;
    end
    if_req = 1'b0; d_req = 1'b0;
    chk_eq("contention_acks", 32'(k), 32'd10);
    repeat (3) @(negedge clk);

    // reset while a load sits in WAIT
    d_addr = 32'h0000_0404; d_we = 1'b0; d_be = 4'hF; d_req = 1'b1;
    repeat (2) @(negedge clk);
    cpu_resetn = 1'b0;
    d_req = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clk);
    cpu_resetn = 1'b1;
    repeat (2) @(negedge clk);
    fetch_txn(32'h0000_0100, 1'b1);
    repeat (2) @(negedge clk);

`ifdef MEM_BUS_ARB_PERF_CNT_EN
    pif0 = perf_if_stall; pd0 = perf_d_stall;
    fork
      data_txn(1'b0, 4'hF, 32'h0000_0480, 32'h0, 1'b1);
      fetch_txn(32'h0000_0020, 1'b0);
    join
    repeat (2) @(negedge clk);
    chk_eq("perf_if_stall_delta", perf_if_stall - pif0, 32'd4);
    chk_eq("perf_d_stall_delta", perf_d_stall - pd0, 32'd0);
`endif

    fork
      begin
        for (int t = 0; t < 40; t++) begin
          repeat ($urandom_range(0, 5)) @(negedge clk);
          r = $urandom();
          fetch_txn({r[31:12], 2'b00, r[9:0]}, 1'b0);
        end
      end
      begin
        for (int t = 0; t < 40; t++) begin
          logic [31:0] a, w;
          logic [3:0]  be;
          repeat ($urandom_range(0, 5)) @(negedge clk);
          a = $urandom(); w = $urandom(); be = 4'($urandom());
          data_txn(1'($urandom()), be, {a[31:12], 2'b01, a[9:0]}, w, 1'b0);
        end
      end
    join

    repeat (10) @(negedge clk);
    chk_eq("if_q_drained", 32'(if_q.size()), 32'd0);
    chk_eq("d_q_drained", 32'(d_q.size()), 32'd0);
    chk_eq("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
